weighted_rr_lock_arbiter: RTL

//  N-way one-hot arbiter for VC/switch allocation in the mesh router. It extends the plain
//  one-hot arbiter with round-robin fairness, a per-port weight (consecutive packets per win)
//  and packet lock: a winner keeps the grant until its tail flit.

---
 rtl/weighted_rr_lock_arbiter_pkg.sv | 13 +
 rtl/weighted_rr_lock_arbiter_pick.sv | 38 +++
 rtl/weighted_rr_lock_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/weighted_rr_lock_arbiter_pkg.sv
// Shared constants for the weighted round-robin lock arbiter.
//   ARB_RR / ARB_FIXED : values for the FIXED_PRIO parameter
//   idx_w()            : width of a binary index for n requesters (min 1)
package weighted_rr_lock_arbiter_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/weighted_rr_lock_arbiter_pick.sv
// Combinational masked priority pick.
// Returns the first requester strictly after the one-hot 'last' position,
// wrapping modulo N.
//   req  in  N   request vector
//   last in  N   one-hot previous winner (1<<(N-1) gives plain index-0-first)
//   pick out N   one-hot winner, zero when req is zero
//   idx  out IW  binary index of pick, zero when req is zero
module rr_priority_pick
   import weighted_rr_lock_arbiter_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  last,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx
);

   logic [N-1:0]   base;
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] hit;

   // Start searching one position above last, rotated so N-1 wraps to 0.
   assign base = {last[N-2:0], last[N-1]};
   assign dbl  = {req, req};
   // Subtracting the start bit borrows up to the first set request at or
   // above it; masking with the inverse isolates exactly that bit.
   assign hit  = dbl & ~(dbl - {{N{1'b0}}, base});
   assign pick = hit[N-1:0] | hit[2*N-1:N];

   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++)
         if (pick[i]) idx = idx | IW'(i);
   end

endmodule

// File: rtl/weighted_rr_lock_arbiter.sv
// N-way one-hot arbiter with round-robin (or fixed) priority, per-port
// burst weight and packet lock. Grant is combinational from request and
// registered state.
//   clk, reset  clock, synchronous active-high reset
//   request     per-port request
//   hold        current transfer is mid-packet; keep the winner locked
//   weight      port i weight at [i*WEIGHT_W +: WEIGHT_W], 0 treated as 1
//   grant       one-hot grant or zero
//   any_grant   |grant
//   grant_idx   binary index of grant, 0 when no grant
module weighted_rr_lock_arbiter
   import weighted_rr_lock_arbiter_pkg::*;
#(
   parameter int ARBITER_WIDTH = 8,
   parameter int WEIGHT_W      = 3,
   parameter int FIXED_PRIO    = ARB_RR
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [ARBITER_WIDTH-1:0]          request,
   input  logic                              hold,
   input  logic [ARBITER_WIDTH*WEIGHT_W-1:0] weight,
   output logic [ARBITER_WIDTH-1:0]          grant,
   output logic                              any_grant,
   output logic [idx_w(ARBITER_WIDTH)-1:0]   grant_idx
);

   localparam int N  = ARBITER_WIDTH;
   localparam int IW = idx_w(N);
   localparam logic [N-1:0] TOP_ONEHOT = {1'b1, {(N-1){1'b0}}};

   logic [N-1:0]        last_q, last_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic                locked_q, locked_d;
   logic [WEIGHT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]        arb_last, pick, owner_oh, grant_raw;
   logic [IW-1:0]       pick_idx, idx_raw;
   logic                lock_hit;
   logic [WEIGHT_W-1:0] w_field;
   logic [WEIGHT_W:0]   w_eff, cnt_base, cnt_inc;

   assign owner_oh = N'(1) << owner_q;
   // Lock only holds while the owner keeps requesting.
   assign lock_hit = locked_q & request[owner_q];
   assign arb_last = (FIXED_PRIO == ARB_FIXED) ? TOP_ONEHOT : last_q;

   rr_priority_pick #(.N(N), .IW(IW)) u_pick (
      .req  (request),
      .last (arb_last),
      .pick (pick),
      .idx  (pick_idx)
   );

   always_comb begin
      grant_raw = lock_hit ? owner_oh : pick;
      idx_raw   = lock_hit ? owner_q  : pick_idx;
      grant     = reset ? '0 : grant_raw;
      grant_idx = reset ? '0 : idx_raw;
      any_grant = |grant;
   end

   // Weight of the port being granted this cycle, 0 promoted to 1; one
   // extra bit so cnt+1 never wraps in the compare.
   always_comb begin
      w_field  = weight[int'(idx_raw)*WEIGHT_W +: WEIGHT_W];
      w_eff    = (w_field == '0) ? (WEIGHT_W+1)'(1) : {1'b0, w_field};
      // A new owner starts counting from zero.
      cnt_base = lock_hit ? {1'b0, cnt_q} : '0;
      cnt_inc  = cnt_base + 1'b1;
   end

   always_comb begin
      last_d   = last_q;
      owner_d  = owner_q;
      locked_d = locked_q;
      cnt_d    = cnt_q;
      if (|grant_raw) begin
         // Owner walked away mid-lock: pointer moves past it.
         if (locked_q && !lock_hit) last_d = owner_oh;
         owner_d = idx_raw;
         if (hold) begin
            locked_d = 1'b1;
            cnt_d    = cnt_base[WEIGHT_W-1:0];
         end else if (cnt_inc < w_eff) begin
            locked_d = 1'b1;
            cnt_d    = cnt_inc[WEIGHT_W-1:0];
         end else begin
            locked_d = 1'b0;
            cnt_d    = '0;
            last_d   = grant_raw;
         end
      end else begin
         locked_d = 1'b0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q   <= TOP_ONEHOT;
         owner_q  <= '0;
         locked_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         last_q   <= last_d;
         owner_q  <= owner_d;
         locked_q <= locked_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
